// File: rtl/data_mem_pkg.sv
// Shared types and constants for the sweepable data memory.
// The sweep FSM state encoding and the Mode input values live here.
package data_mem_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, DUMP, DONE} sweep_state_t;

  localparam logic MODE_CLEAR = 1'b0;
  localparam logic MODE_DUMP  = 1'b1;

endpackage

// File: rtl/data_mem_sweep_mem_array.sv
// Plain W x 2**A storage: one write port, a CPU read port and a sweep read port.
// Contents are deliberately not reset.
module mem_array #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata,
  input  logic [A-1:0] saddr,
  output logic [W-1:0] sdata
);

  logic [W-1:0] mem [2**A];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
  assign sdata = mem[saddr];

endmodule

// File: rtl/data_mem_sweep.sv
// Data memory with a built-in CLEAR / DUMP sweep engine and a Start/Ack
// four-phase handshake; the CPU port stays usable for reads during sweeps.
module data_mem_sweep
  import data_mem_pkg::*;
#(
  parameter int           W        = 8,
  parameter int           A        = 8,
  parameter logic [W-1:0] CLR_VAL  = '0,
  parameter bit           REG_READ = 1'b0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Mode,
  output logic         Busy,
  output logic         Ack,
  input  logic         WriteEn,
  input  logic [A-1:0] Addr,
  input  logic [W-1:0] DataIn,
  output logic [W-1:0] DataOut,
  output logic         DumpValid,
  output logic [A-1:0] DumpAddr,
  output logic [W-1:0] DumpData
);

  localparam int DEPTH = 1 << A;
  // One extra counter bit so the step past the last word never aliases to 0.
  localparam logic [A:0] LAST = (A+1)'(DEPTH - 1);

  sweep_state_t state, state_nxt;
  logic [A:0]   cnt, cnt_nxt;
  logic         mem_we;
  logic [A-1:0] mem_waddr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] cpu_rdata;
  logic [W-1:0] sweep_rdata;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = (Mode == MODE_DUMP) ? DUMP : CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR, DUMP: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (!Start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state == CLEAR) || (state == DUMP);
  assign Ack  = (state == DONE);

  // The clear sweep owns the write port; CPU writes are dropped while busy.
  assign mem_we    = (state == CLEAR) || (WriteEn && !Busy);
  assign mem_waddr = (state == CLEAR) ? cnt[A-1:0] : Addr;
  assign mem_wdata = (state == CLEAR) ? CLR_VAL : DataIn;

  mem_array #(.W(W), .A(A)) u_mem (
    .clk   (Clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (Addr),
    .rdata (cpu_rdata),
    .saddr (cnt[A-1:0]),
    .sdata (sweep_rdata)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DumpValid <= 1'b0;
      DumpAddr  <= '0;
      DumpData  <= '0;
    end else begin
      DumpValid <= (state == DUMP);
      if (state == DUMP) begin
        DumpAddr <= cnt[A-1:0];
        DumpData <= sweep_rdata;
      end
    end
  end

  generate
    if (REG_READ) begin : g_reg_read
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) DataOut <= '0;
        else       DataOut <= cpu_rdata;
      end
    end else begin : g_comb_read
      assign DataOut = cpu_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_sweep.sv
// Bench for data_mem_sweep: a combinational-read and a registered-read
// instance share stimulus and are checked against a behavioural memory model.
module tb_data_mem_sweep;

  localparam int W     = 8;
  localparam int A     = 8;
  localparam int DEPTH = 256;

  logic         Clk = 1'b0;
  logic         Reset, Start, Mode, WriteEn;
  logic [A-1:0] Addr;
  logic [W-1:0] DataIn;

  logic         Busy, Ack, DumpValid;
  logic [W-1:0] DataOut, DumpData;
  logic [A-1:0] DumpAddr;

  logic         r_busy, r_ack, r_dump_valid;
  logic [W-1:0] r_data_out, r_dump_data;
  logic [A-1:0] r_dump_addr;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] ref_mem [DEPTH];

  always #5 Clk = ~Clk;

  data_mem_sweep #(.W(W), .A(A), .CLR_VAL(8'h00), .REG_READ(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Busy(Busy), .Ack(Ack),
    .WriteEn(WriteEn), .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut),
    .DumpValid(DumpValid), .DumpAddr(DumpAddr), .DumpData(DumpData)
  );

  data_mem_sweep #(.W(W), .A(A), .CLR_VAL(8'h00), .REG_READ(1'b1)) dut_r (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Busy(r_busy), .Ack(r_ack),
    .WriteEn(WriteEn), .Addr(Addr), .DataIn(DataIn), .DataOut(r_data_out),
    .DumpValid(r_dump_valid), .DumpAddr(r_dump_addr), .DumpData(r_dump_data)
  );

  // Called at a falling edge; performs one CPU write on the next rising edge.
  task automatic cpu_write(input int a, input logic [W-1:0] d);
    WriteEn = 1'b1;
    Addr    = 8'(a);
    DataIn  = d;
    @(negedge Clk);
    WriteEn = 1'b0;
    ref_mem[a] = d;
  endtask

  // Raises Start and waits for Busy to fall; returns at the first non-busy cycle.
  task automatic run_sweep(input logic m, output int busy_cycles, output bit timeout,
                           output logic ack_now);
    Start = 1'b1;
    Mode  = m;
    busy_cycles = 0;
    timeout = 1'b1;
    ack_now = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (Busy) busy_cycles++;
      else if (i > 0) begin
        timeout = 1'b0;
        ack_now = Ack;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; Mode = 1'b0; WriteEn = 1'b0; Addr = '0; DataIn = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    total++; if (Ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", Ack); end
    total++; if (DumpValid !== 1'b0) begin bad++; $display("FAIL reset_dump_valid got=%b exp=0", DumpValid); end
    total++; if (DumpAddr !== 8'h00) begin bad++; $display("FAIL reset_dump_addr got=%h exp=00", DumpAddr); end
    total++; if (DumpData !== 8'h00) begin bad++; $display("FAIL reset_dump_data got=%h exp=00", DumpData); end
    total++; if (r_data_out !== 8'h00) begin bad++; $display("FAIL reset_reg_dout got=%h exp=00", r_data_out); end
    @(negedge Clk);
  endtask

  task automatic test_clear_sweep;
    int bc; bit to; logic ak; int a;
    for (int i = 0; i < DEPTH; i++) cpu_write(i, 8'hA5);
    for (int j = 0; j < 6; j++) begin
      a = int'($urandom_range(DEPTH-1, 0));
      Addr = 8'(a); #1;
      total++; if (DataOut !== ref_mem[a]) begin bad++; $display("FAIL pre_clear_read addr=%0d got=%h exp=%h", a, DataOut, ref_mem[a]); end
      @(negedge Clk);
    end
    run_sweep(1'b0, bc, to, ak);
    total++; if (to) begin bad++; $display("FAIL clear_timeout busy_cycles=%0d", bc); end
    total++; if (bc != DEPTH) begin bad++; $display("FAIL clear_busy_len got=%0d exp=%0d", bc, DEPTH); end
    total++; if (ak !== 1'b1) begin bad++; $display("FAIL clear_ack_rise got=%b exp=1", ak); end
    Start = 1'b0;
    @(negedge Clk);
    total++; if (Ack !== 1'b0) begin bad++; $display("FAIL clear_ack_drop got=%b exp=0", Ack); end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      Addr = 8'(i); #1;
      total++; if (DataOut !== ref_mem[i]) begin bad++; $display("FAIL clear_read addr=%0d got=%h exp=%h", i, DataOut, ref_mem[i]); end
      @(negedge Clk);
    end
  endtask

  task automatic test_write_during_clear;
    int bc; bit done; int a;
    for (int j = 0; j < 16; j++) cpu_write(int'($urandom_range(DEPTH-1, 0)), 8'($urandom_range(255, 1)));
    cpu_write(3, 8'($urandom_range(255, 1)));
    Start = 1'b1; Mode = 1'b0; bc = 0; done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      WriteEn = 1'b0;
      if (Busy) begin
        bc++;
        if (bc == 10) begin WriteEn = 1'b1; Addr = 8'd3; DataIn = 8'h77; end
      end else if (i > 0) begin
        done = 1'b1;
        break;
      end
    end
    WriteEn = 1'b0;
    total++; if (!done || bc != DEPTH) begin bad++; $display("FAIL wdc_busy_len got=%0d exp=%0d", bc, DEPTH); end
    Start = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    Addr = 8'd3; #1;
    total++; if (DataOut !== 8'h00) begin bad++; $display("FAIL wdc_word3 got=%h exp=00", DataOut); end
    @(negedge Clk);
    for (int j = 0; j < 8; j++) begin
      a = int'($urandom_range(DEPTH-1, 0));
      Addr = 8'(a); #1;
      total++; if (DataOut !== ref_mem[a]) begin bad++; $display("FAIL wdc_read addr=%0d got=%h exp=%h", a, DataOut, ref_mem[a]); end
      @(negedge Clk);
    end
  endtask

  task automatic test_dump;
    int idx; int runs; bit prev_v; bit first_done_seen; bit finished;
    for (int i = 0; i < DEPTH; i++) cpu_write(i, 8'($urandom));
    cpu_write(8, 8'd5);
    cpu_write(255, 8'hFF);
    Start = 1'b1; Mode = 1'b1;
    idx = 0; runs = 0; prev_v = 1'b0; first_done_seen = 1'b0; finished = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge Clk);
      if (DumpValid === 1'b1) begin
        if (!prev_v) runs++;
        total++; if (DumpAddr !== 8'(idx)) begin bad++; $display("FAIL dump_addr n=%0d got=%0d exp=%0d", idx, DumpAddr, idx); end
        if (idx < DEPTH) begin
          total++; if (DumpData !== ref_mem[idx]) begin bad++; $display("FAIL dump_data addr=%0d got=%h exp=%h", idx, DumpData, ref_mem[idx]); end
        end
        if (idx == 8) begin
          total++; if (DumpData !== 8'd5) begin bad++; $display("FAIL dump_word8 got=%h exp=05", DumpData); end
        end
        if (idx == 255) begin
          total++; if (DumpData !== 8'hFF) begin bad++; $display("FAIL dump_word255 got=%h exp=ff", DumpData); end
        end
        idx++;
      end
      if (Ack === 1'b1 && !first_done_seen) begin
        first_done_seen = 1'b1;
        total++; if (DumpValid !== 1'b1) begin bad++; $display("FAIL dump_last_in_done got=%b exp=1", DumpValid); end
      end
      prev_v = (DumpValid === 1'b1);
      if (first_done_seen && DumpValid !== 1'b1) begin finished = 1'b1; break; end
    end
    total++; if (!finished) begin bad++; $display("FAIL dump_timeout got=0 exp=1"); end
    total++; if (idx != DEPTH) begin bad++; $display("FAIL dump_valid_len got=%0d exp=%0d", idx, DEPTH); end
    total++; if (runs != 1) begin bad++; $display("FAIL dump_contiguous runs=%0d exp=1", runs); end
    Start = 1'b0;
    @(negedge Clk);
    total++; if (Ack !== 1'b0) begin bad++; $display("FAIL dump_ack_drop got=%b exp=0", Ack); end
  endtask

  task automatic test_reset_mid_sweep;
    int bc; bit hit;
    for (int i = 0; i < DEPTH; i++) cpu_write(i, 8'h11);
    Start = 1'b1; Mode = 1'b0; bc = 0; hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (Busy) bc++;
      if (bc == 101) begin
        // Counter is at 100: words 0..99 have been cleared.
        Reset = 1'b1; Start = 1'b0;
        #1;
        hit = 1'b1;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", Busy); end
        total++; if (Ack !== 1'b0) begin bad++; $display("FAIL rst_mid_ack got=%b exp=0", Ack); end
        total++; if (DumpValid !== 1'b0) begin bad++; $display("FAIL rst_mid_dump_valid got=%b exp=0", DumpValid); end
        total++; if (r_data_out !== 8'h00) begin bad++; $display("FAIL rst_mid_reg_dout got=%h exp=00", r_data_out); end
        #1 Reset = 1'b0;
        break;
      end
    end
    total++; if (!hit) begin bad++; $display("FAIL rst_mid_timeout busy_cycles=%0d", bc); end
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_mid_stays_idle got=%b exp=0", Busy); end
    for (int i = 0; i < 100; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      Addr = 8'(i); #1;
      total++; if (DataOut !== ref_mem[i]) begin bad++; $display("FAIL rst_mid_read addr=%0d got=%h exp=%h", i, DataOut, ref_mem[i]); end
      @(negedge Clk);
    end
  endtask

  task automatic test_handshake_hold;
    int bc; bit to; logic ak;
    run_sweep(1'b1, bc, to, ak);
    total++; if (to || ak !== 1'b1) begin bad++; $display("FAIL hs_sweep_done ack=%b timeout=%0d", ak, to); end
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      total++; if (Ack !== 1'b1 || Busy !== 1'b0 || DumpValid !== 1'b0) begin
        bad++; $display("FAIL hs_hold cycle=%0d ack=%b busy=%b dv=%b exp=1/0/0", i, Ack, Busy, DumpValid);
      end
    end
    Start = 1'b0;
    @(negedge Clk);
    total++; if (Ack !== 1'b0) begin bad++; $display("FAIL hs_ack_drop got=%b exp=0", Ack); end
    @(negedge Clk);
    total++; if (Busy !== 1'b0 || Ack !== 1'b0) begin bad++; $display("FAIL hs_idle busy=%b ack=%b exp=0/0", Busy, Ack); end
  endtask

  task automatic test_reg_read;
    int prev_a; int a;
    cpu_write(9, 8'h3C);
    Addr = 8'd9;
    @(negedge Clk);
    total++; if (r_data_out !== 8'h3C) begin bad++; $display("FAIL rr_read9 got=%h exp=3c", r_data_out); end
    WriteEn = 1'b1; Addr = 8'd9; DataIn = 8'h44;
    @(negedge Clk);
    WriteEn = 1'b0;
    ref_mem[9] = 8'h44;
    total++; if (r_data_out !== 8'h3C) begin bad++; $display("FAIL rr_read_before_write got=%h exp=3c", r_data_out); end
    @(negedge Clk);
    total++; if (r_data_out !== 8'h44) begin bad++; $display("FAIL rr_read_after_write got=%h exp=44", r_data_out); end
    prev_a = 9;
    for (int j = 0; j < 20; j++) begin
      a = int'($urandom_range(DEPTH-1, 0));
      Addr = 8'(a);
      @(negedge Clk);
      total++; if (r_data_out !== ref_mem[a]) begin bad++; $display("FAIL rr_random addr=%0d got=%h exp=%h", a, r_data_out, ref_mem[a]); end
      prev_a = a;
    end
    total++; if (DataOut !== ref_mem[prev_a]) begin bad++; $display("FAIL rr_comb_last addr=%0d got=%h exp=%h", prev_a, DataOut, ref_mem[prev_a]); end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_write_during_clear();
    test_dump();
    test_reset_mid_sweep();
    test_handshake_hold();
    test_reg_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_sweep.md
Name: data_mem_sweep

Overview:
Parametrised successor to the 256x8 data memory block. It adds a built-in sweep engine, so benches and the top level no longer poke the array hierarchically.
- CLEAR mode fills every word with a constant.
- DUMP mode streams every word out, tagged with its address.
- Sweeps start and finish through a Start/Ack 4-phase handshake.
- The block replaces the data memory instance inside the processor top level.

Parameters:
W, 8, data word width in bits
A, 8, address width; depth DEPTH = 2**A
CLR_VAL, 0, W-bit value written by a CLEAR sweep
REG_READ, 0, 0 = DataOut is combinational from Addr; 1 = DataOut is registered (1-cycle latency)

Ports:
Clk  in  1  single clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  sweep request (level); sampled in IDLE
Mode  in  1  0 = CLEAR, 1 = DUMP; sampled together with Start
Busy  out  1  high while a sweep is running
Ack  out  1  sweep done; held until Start is low
WriteEn  in  1  CPU write enable
Addr  in  A  CPU read/write address
DataIn  in  W  CPU write data
DataOut  out  W  CPU read data
DumpValid  out  1  DumpAddr/DumpData are valid this cycle
DumpAddr  out  A  address of the dumped word
DumpData  out  W  contents of the dumped word

Behaviour:
- Reset (asynchronous): state to IDLE; counter, Busy, Ack, DumpValid, DumpAddr, DumpData all 0; registered DataOut 0. Array contents are NOT touched.
- States: IDLE, CLEAR, DUMP, DONE.
- IDLE:
  - Start=1 moves to CLEAR (Mode=0) or DUMP (Mode=1) at the next edge; counter = 0.
  - A WriteEn in the same cycle is still performed.
- CLEAR, counter k:
  - Writes CLR_VAL to word k; counter advances by 1.
  - After k = DEPTH-1, moves to DONE.
  - Busy is high for exactly DEPTH cycles.
- DUMP, counter k:
  - At the edge, registers DumpValid=1, DumpAddr=k, DumpData=word k; counter advances by 1.
  - Outputs are visible one cycle later, so DumpValid is high for DEPTH consecutive cycles, the last one being the first DONE cycle.
  - No backpressure.
  - After k = DEPTH-1, moves to DONE.
- DONE:
  - Ack=1, Busy=0.
  - Stays in DONE while Start=1; moves to IDLE at the first edge with Start=0, and Ack drops then.
  - Start is ignored in DONE; a new sweep needs Start low for at least one IDLE cycle.
- CPU port:
  - Write is synchronous: word[Addr] <= DataIn when WriteEn && !Busy.
  - While Busy, writes are silently dropped.
  - Reads are always serviced, including during sweeps.
  - REG_READ=1: DataOut shows word[Addr] one cycle after Addr is presented. A write to the same address in that cycle returns the old data (read-before-write).
- Counter is A+1 bits wide so DEPTH-1 is detected without wrap aliasing; it wraps to 0 on entry to any sweep.
- Reset during a sweep: immediate return to IDLE. Words already cleared stay CLR_VAL; the rest keep their old contents.

Decomposition:
- Package data_mem_pkg holds:
  - typedef enum logic [1:0] sweep_state_t {IDLE, CLEAR, DUMP, DONE};
  - constants MODE_CLEAR = 1'b0 and MODE_DUMP = 1'b1.
- One natural sub-module: mem_array. It holds the W x DEPTH storage with one write port, one CPU read port and one sweep read port, and contains no control logic.
- The FSM, counter and handshake live in data_mem_sweep.

Test Plan:
All scenarios use W=8, A=8.
1. Write 8'hA5 to addrs 0..255, then Start=1/Mode=0 -> Busy high exactly 256 cycles, Ack rises the next cycle; every read returns 8'h00.
2. Write word[8]=8'd5 and word[255]=8'hFF, then Start=1/Mode=1 -> DumpValid high for 256 consecutive cycles, DumpAddr 0..255 in order; DumpData=5 at addr 8 and 8'hFF at addr 255.
3. During a CLEAR, assert WriteEn with Addr=3, DataIn=8'h77 -> write dropped; word[3]=0 after Ack.
4. Fill all words with 8'h11, start CLEAR, assert Reset when the counter reaches 100 -> Busy/Ack/DumpValid go 0 immediately; words 0..99 = 0, words 100..255 = 8'h11.
5. Hold Start high after the sweep completes -> Ack stays 1 and no second sweep starts; drop Start -> Ack goes 0 on the next edge, state IDLE.
6. REG_READ=1: write 8'h3C to addr 9, then read addr 9 -> DataOut=8'h3C one cycle after Addr is presented; a same-cycle write to 9 of 8'h44 returns 8'h3C first, then 8'h44.
